execute_stage: RTL and testbench

Execute stage of the four-stage pipelined controller. It sits directly downstream of the register-file stage and consumes the two operands that stage reads out. It runs one ALU operation per instruction and drives the register file's write-back port: destination, 32-bit data and 3-bit flags. Single-cycle operations complete in one clock; MUL runs on an iterative multiplier and stalls the upstream stages until it finishes.

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/exec_mul_iter.sv | 75 +++++++
 rtl/execute_stage.sv | 148 ++++++++++++++
 tb/tb_execute_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared controller definitions: opcodes, flag positions, widths and the execute FSM states.
// Used by decode, register file and execute stages.
package ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 4;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic {StIdle, StBusy} ex_state_e;

    function automatic logic [2:0] calc_flags(input logic carry, input logic [DATA_W-1:0] res);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = carry;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[DATA_W-1];
        return f;
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative unsigned multiplier: consumes MUL_DIGIT bits of B per cycle into a 64-bit accumulator.
// product_o is the accumulator value after the current step, valid while done_o is high.
module exec_mul_iter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int unsigned Iters = DATA_W / MUL_DIGIT;
    localparam int unsigned CntW  = $clog2(Iters);
    localparam int unsigned PpW   = DATA_W + MUL_DIGIT;

    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [MUL_DIGIT-1:0] digit;
    logic [PpW-1:0]      pp;

    always_comb begin
        digit    = b_q[int'(cnt_q)*MUL_DIGIT +: MUL_DIGIT];
        pp       = {{MUL_DIGIT{1'b0}}, a_q} * {{DATA_W{1'b0}}, digit};
        acc_step = acc_q + ({{(2*DATA_W-PpW){1'b0}}, pp} << (int'(cnt_q) * MUL_DIGIT));
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(Iters - 1)) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CntW'(Iters - 1));
    assign product_o = acc_step;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL, driving the register-file write-back port.
// Stalls upstream while a multiply is in flight.
module execute_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_DIGIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid_in,
    input  logic [3:0]        ex_opcode_in,
    input  logic [3:0]        ex_dest_in,
    input  logic [DATA_W-1:0] ex_s1_data_in,
    input  logic [DATA_W-1:0] ex_s2_data_in,
    output logic              ex_stall_out,
    output logic              wb_valid_out,
    output logic [3:0]        wb_dest_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [2:0]        wb_flags_out
);
    import ctrl_pkg::*;

    ex_state_e           state_q, state_d;
    logic                wb_valid_q, wb_valid_d;
    logic [3:0]          wb_dest_q, wb_dest_d, mul_dest_q, mul_dest_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [2:0]          wb_flags_q, wb_flags_d;

    logic                mul_start, mul_busy, mul_done, alu_load;
    logic [2*DATA_W-1:0] mul_product;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic [DATA_W:0]     sum33, shl33, shr33;

    exec_mul_iter #(
        .DATA_W   (DATA_W),
        .MUL_DIGIT(MUL_DIGIT)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (mul_start),
        .a_i      (ex_s1_data_in),
        .b_i      (ex_s2_data_in),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    // Shifts run one bit wider so the last bit shifted out lands in bit DATA_W (SHL) or bit 0 (SHR).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum33   = '0;
        shl33   = {1'b0, ex_s1_data_in} << ex_s2_data_in[4:0];
        shr33   = {ex_s1_data_in, 1'b0} >> ex_s2_data_in[4:0];
        case (ex_opcode_in)
            OP_ADD: begin
                sum33   = {1'b0, ex_s1_data_in} + {1'b0, ex_s2_data_in};
                alu_res = sum33[DATA_W-1:0];
                alu_c   = sum33[DATA_W];
            end
            OP_SUB: begin
                sum33   = {1'b0, ex_s1_data_in} - {1'b0, ex_s2_data_in};
                alu_res = sum33[DATA_W-1:0];
                alu_c   = sum33[DATA_W];
            end
            OP_AND: alu_res = ex_s1_data_in & ex_s2_data_in;
            OP_OR:  alu_res = ex_s1_data_in | ex_s2_data_in;
            OP_XOR: alu_res = ex_s1_data_in ^ ex_s2_data_in;
            OP_NOT: alu_res = ~ex_s1_data_in;
            OP_SHL: begin
                alu_res = shl33[DATA_W-1:0];
                alu_c   = shl33[DATA_W];
            end
            OP_SHR: begin
                alu_res = shr33[DATA_W:1];
                alu_c   = shr33[0];
            end
            OP_MOV: alu_res = ex_s1_data_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mul_start) state_d = StBusy;
            StBusy: if (mul_done)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ex_stall_out = (state_q == StBusy);
        mul_start    = (state_q == StIdle) && ex_valid_in && (ex_opcode_in == OP_MUL);
        alu_load     = (state_q == StIdle) && ex_valid_in &&
                       (ex_opcode_in >= OP_ADD) && (ex_opcode_in <= OP_MOV);
    end

    // Write-back fields hold when nothing completes; the register file rewrites them idempotently.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        wb_flags_d = wb_flags_q;
        mul_dest_d = mul_start ? ex_dest_in : mul_dest_q;
        if (alu_load) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = ex_dest_in;
            wb_data_d  = alu_res;
            wb_flags_d = calc_flags(alu_c, alu_res);
        end else if (mul_done && mul_busy) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = mul_dest_q;
            wb_data_d  = mul_product[DATA_W-1:0];
            wb_flags_d = calc_flags(|mul_product[2*DATA_W-1:DATA_W], mul_product[DATA_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= 3'b010;
            mul_dest_q <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            wb_flags_q <= wb_flags_d;
            mul_dest_q <= mul_dest_d;
        end
    end

    assign wb_valid_out = wb_valid_q;
    assign wb_dest_out  = wb_dest_q;
    assign wb_data_out  = wb_data_q;
    assign wb_flags_out = wb_flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized ops against a
// behavioural model built from plain 64-bit arithmetic.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid_in;
    logic [3:0]  ex_opcode_in;
    logic [3:0]  ex_dest_in;
    logic [31:0] ex_s1_data_in;
    logic [31:0] ex_s2_data_in;
    logic        ex_stall_out;
    logic        wb_valid_out;
    logic [3:0]  wb_dest_out;
    logic [31:0] wb_data_out;
    logic [2:0]  wb_flags_out;

    int total = 0;
    int bad   = 0;

    // Shadow of the last write-back seen, used to check hold behaviour.
    logic [3:0]  last_dest;
    logic [31:0] last_data;
    logic [2:0]  last_flags;

    execute_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid_in  (ex_valid_in),
        .ex_opcode_in (ex_opcode_in),
        .ex_dest_in   (ex_dest_in),
        .ex_s1_data_in(ex_s1_data_in),
        .ex_s2_data_in(ex_s2_data_in),
        .ex_stall_out (ex_stall_out),
        .wb_valid_out (wb_valid_out),
        .wb_dest_out  (wb_dest_out),
        .wb_data_out  (wb_data_out),
        .wb_flags_out (wb_flags_out)
    );

    always #5 clk = ~clk;

    // Reference: result and {C,Z,N} computed straight from the operation definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [2:0] f);
        logic [63:0] w;
        logic        c;
        int          sh;
        sh = int'(b[4:0]);
        c  = 1'b0;
        r  = 32'h0;
        case (op)
            4'd1: begin w = {32'h0, a} + {32'h0, b}; r = w[31:0]; c = (w > 64'hFFFF_FFFF); end
            4'd2: begin r = a - b; c = (a < b); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = ~a;
            4'd7: begin
                w = {32'h0, a} << sh;
                r = w[31:0];
                c = (sh == 0) ? 1'b0 : a[32-sh];
            end
            4'd8: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
            4'd9: r = a;
            4'd10: begin
                w = {32'h0, a} * {32'h0, b};
                r = w[31:0];
                c = (w[63:32] != 32'h0);
            end
            default: r = 32'h0;
        endcase
        f = {c, (r == 32'h0), r[31]};
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] d,
                         input logic [31:0] a, input logic [31:0] b);
        ex_valid_in   = v;
        ex_opcode_in  = op;
        ex_dest_in    = d;
        ex_s1_data_in = a;
        ex_s2_data_in = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string name, input logic v, input logic [3:0] d,
                            input logic [31:0] r, input logic [2:0] f);
        total++;
        if (wb_valid_out !== v || wb_dest_out !== d || wb_data_out !== r || wb_flags_out !== f) begin
            bad++;
            $display("FAIL %s: got v=%b d=%0d data=%h flags=%b, want v=%b d=%0d data=%h flags=%b",
                     name, wb_valid_out, wb_dest_out, wb_data_out, wb_flags_out, v, d, r, f);
        end
        last_dest  = d;
        last_data  = r;
        last_flags = f;
    endtask

    // Accepts an op that is already driven and waits for its result, checking stall timing for MUL.
    task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] d,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [2:0]  f;
        int          cycles;
        model(op, a, b, r, f);
        drive(1'b1, op, d, a, b);
        step();
        if (op == 4'd10) begin
            cycles = 0;
            while (!wb_valid_out && cycles < 20) begin
                total++;
                if (ex_stall_out !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall: got %b want 1 at busy cycle %0d", name, ex_stall_out, cycles);
                end
                step();
                cycles++;
            end
            total++;
            if (cycles != 8) begin
                bad++;
                $display("FAIL %s latency: got %0d cycles want 8", name, cycles);
            end
        end
        check_wb(name, 1'b1, d, r, f);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
        step();
        step();
        total++;
        if (ex_stall_out !== 1'b0) begin
            bad++;
            $display("FAIL reset stall: got %b want 0", ex_stall_out);
        end
        check_wb("reset", 1'b0, 4'd0, 32'h0, 3'b010);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_alu_directed();
        run_op("add_wrap", 4'd1, 4'd3, 32'hFFFF_FFFF, 32'h1);
        total++;
        if (wb_flags_out !== 3'b110 || wb_data_out !== 32'h0) begin
            bad++;
            $display("FAIL add_wrap const: got data=%h flags=%b want 0/110", wb_data_out, wb_flags_out);
        end
        run_op("sub_neg", 4'd2, 4'd4, 32'd5, 32'd7);
        total++;
        if (wb_data_out !== 32'hFFFF_FFFE || wb_flags_out !== 3'b101) begin
            bad++;
            $display("FAIL sub_neg const: got data=%h flags=%b want fffffffe/101",
                     wb_data_out, wb_flags_out);
        end
        run_op("shl_carry", 4'd7, 4'd5, 32'h8000_0001, 32'd1);
        total++;
        if (wb_data_out !== 32'h2 || wb_flags_out[2] !== 1'b1) begin
            bad++;
            $display("FAIL shl_carry const: got data=%h C=%b want 2/1", wb_data_out, wb_flags_out[2]);
        end
        run_op("shr_zero_sh", 4'd8, 4'd6, 32'h8000_0001, 32'd0);
        run_op("shr_31", 4'd8, 4'd6, 32'hC000_0000, 32'd31);
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic test_mul_stall();
        int cycles;
        drive(1'b1, 4'd10, 4'd9, 32'h0001_0000, 32'h0001_0000);
        step();
        // Upstream presents the next instruction and holds it while stalled.
        drive(1'b1, 4'd1, 4'd2, 32'd10, 32'd20);
        cycles = 0;
        while (!wb_valid_out && cycles < 20) begin
            total++;
            if (ex_stall_out !== 1'b1) begin
                bad++;
                $display("FAIL mul_big stall: got %b want 1 at cycle %0d", ex_stall_out, cycles);
            end
            step();
            cycles++;
        end
        total++;
        if (cycles != 8 || ex_stall_out !== 1'b0) begin
            bad++;
            $display("FAIL mul_big timing: got %0d cycles stall=%b want 8/0", cycles, ex_stall_out);
        end
        check_wb("mul_big", 1'b1, 4'd9, 32'h0, 3'b110);
        step();
        check_wb("held_add", 1'b1, 4'd2, 32'd30, 3'b000);
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic test_mul_small();
        run_op("mul_small", 4'd10, 4'd7, 32'd1234, 32'd5678);
        total++;
        if (wb_data_out !== 32'd7006652 || wb_flags_out !== 3'b000) begin
            bad++;
            $display("FAIL mul_small const: got data=%0d flags=%b want 7006652/000",
                     wb_data_out, wb_flags_out);
        end
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
        step();
        check_wb("mul_small_pulse", 1'b0, last_dest, last_data, last_flags);
    endtask

    task automatic test_hold();
        run_op("hold_add", 4'd1, 4'd11, 32'h7FFF_FFFF, 32'h1);
        drive(1'b1, 4'd13, 4'd1, 32'h1234, 32'h5678);
        step();
        check_wb("hold_op13", 1'b0, 4'd11, 32'h8000_0000, 3'b001);
        drive(1'b0, 4'd1, 4'd2, 32'h1, 32'h1);
        step();
        check_wb("hold_invalid", 1'b0, 4'd11, 32'h8000_0000, 3'b001);
        drive(1'b1, 4'd0, 4'd2, 32'h1, 32'h1);
        step();
        check_wb("hold_nop", 1'b0, 4'd11, 32'h8000_0000, 3'b001);
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 4'd10, 4'd8, 32'hDEAD_BEEF, 32'h1234_5678);
        step();
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        total++;
        if (ex_stall_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid stall: got %b want 0", ex_stall_out);
        end
        check_wb("rst_mid", 1'b0, 4'd0, 32'h0, 3'b010);
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_wb("rst_mid_quiet", 1'b0, 4'd0, 32'h0, 3'b010);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 9));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            run_op("b2b", op, 4'($urandom), a, b);
        end
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    task automatic test_random_mix();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        v;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 3) != 0);
            a  = $urandom;
            b  = (op == 4'd10 && i % 3 == 0) ? 32'($urandom_range(0, 65535)) : $urandom;
            if (v && op >= 4'd1 && op <= 4'd10) begin
                run_op("rand", op, 4'($urandom), a, b);
            end else begin
                drive(v, op, 4'($urandom), a, b);
                step();
                check_wb("rand_idle", 1'b0, last_dest, last_data, last_flags);
            end
        end
        drive(1'b0, 4'd0, 4'd0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_mul_stall();
        test_mul_small();
        test_hold();
        test_reset_mid_mul();
        test_back_to_back();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
